// File: rtl/period_meter_pkg.sv
// rtl/period_meter_pkg.sv - shared state encoding, defaults and test-period constants for period_meter
package period_meter_pkg;

  // Default widths: 24-bit counter, two-flop synchroniser
  localparam int W_DEFAULT           = 24;
  localparam int SYNC_STAGES_DEFAULT = 2;

  // Measurement FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_MEASURE = 2'd2
  } state_t;

  // Edge-to-edge intervals used when exercising the meter against known dividers
  localparam int TP_BASIC     = 10;
  localparam int TP_OVERWRITE = 12;
  localparam int TP_REENABLE  = 8;
  localparam int TP_SAT_LONG  = 20;
  localparam int TP_SAT_SHORT = 7;

endpackage

// File: rtl/period_meter_edge_sync.sv
// rtl/period_meter_edge_sync.sv - sig_in synchroniser and one-cycle rising-edge detector
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic e
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift sig_in through the synchroniser; everything resets high so a
  // line already high at reset release never looks like a rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign e = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/period_meter.sv
// rtl/period_meter.sv - measures clk cycles between rising edges of sig_in, valid/ack result
module period_meter
  import period_meter_pkg::*;
#(
  parameter int W           = W_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         sig_in,
  input  logic         ack,
  output logic [W-1:0] period,
  output logic         valid,
  output logic         ovf,
  output logic         lost
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic         e;
  state_t       state_q;
  state_t       state_d;
  logic [W-1:0] cnt_q;
  logic         cnt_clear;
  logic         cnt_load1;
  logic         cnt_inc;
  logic         take;

  edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk    (clk),
    .rst    (rst),
    .sig_in (sig_in),
    .e      (e)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state: enable low always wins and drops back to IDLE
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    state_d = ST_ARMED;
        ST_ARMED:   if (e) state_d = ST_MEASURE;
        ST_MEASURE: state_d = ST_MEASURE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Counter and result controls; an edge while disabled is ignored
  always_comb begin
    cnt_clear = 1'b0;
    cnt_load1 = 1'b0;
    cnt_inc   = 1'b0;
    take      = 1'b0;
    if (!enable) begin
      cnt_clear = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE:  cnt_clear = 1'b1;
        ST_ARMED: cnt_load1 = e;
        ST_MEASURE: begin
          if (e) begin
            cnt_load1 = 1'b1;
            take      = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        default:  cnt_clear = 1'b1;
      endcase
    end
  end

  // Interval counter: restarts at 1 on each edge, sticks at all-ones
  always_ff @(posedge clk) begin
    if (rst || cnt_clear)              cnt_q <= '0;
    else if (cnt_load1)                cnt_q <= W'(1);
    else if (cnt_inc && cnt_q != CNT_MAX) cnt_q <= cnt_q + W'(1);
  end

  // Result registers and valid/ack handshake; lost records an unacked overwrite
  always_ff @(posedge clk) begin
    if (rst) begin
      period <= '0;
      ovf    <= 1'b0;
      valid  <= 1'b0;
      lost   <= 1'b0;
    end else if (take) begin
      period <= cnt_q;
      ovf    <= (cnt_q == CNT_MAX);
      valid  <= 1'b1;
      if (valid && !ack)     lost <= 1'b1;
      else if (valid && ack) lost <= 1'b0;
    end else if (valid && ack) begin
      valid <= 1'b0;
      lost  <= 1'b0;
    end
  end

endmodule
